// File: rtl/cw305_bus_pkg.sv
// cw305_bus_pkg: shared state encoding, default bus timing and burst address helper for the USB bus master.
package cw305_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_NEXT,
        ST_DONE
    } bus_state_e;

    localparam int DEF_ADDR_WIDTH   = 21;
    localparam int DEF_BYTECNT_SIZE = 7;
    localparam int DEF_SETUP        = 1;
    localparam int DEF_STROBE       = 2;
    localparam int DEF_HOLD         = 1;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

    // Increment only the low byte-count field, wrapping inside it; upper bits pass through.
    function automatic logic [63:0] burst_next_addr(input logic [63:0] addr, input int unsigned cnt_bits);
        logic [63:0] mask;
        mask = (64'd1 << cnt_bits) - 64'd1;
        return (addr & ~mask) | ((addr + 64'd1) & mask);
    endfunction

endpackage

// File: rtl/cw305_bus_phase_timer.sv
// cw305_bus_phase_timer: loadable down-counter that flags the last cycle of a bus phase.
//   usb_clk  : clock
//   reset_i  : synchronous active-high reset
//   load     : load load_val this cycle (phase entry)
//   load_val : phase length minus one
//   last     : current cycle is the final cycle of the phase
module cw305_bus_phase_timer #(
    parameter int pMAX = 2,
    localparam int CW = $clog2(pMAX + 1)
) (
    input  logic          usb_clk,
    input  logic          reset_i,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          last
);

    logic [CW-1:0] cnt;

    always_ff @(posedge usb_clk) begin
        if (reset_i)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign last = cnt == '0;

endmodule

// File: rtl/cw305_usb_bus_master.sv
// cw305_usb_bus_master: turns command/stream requests into timed SAM3U-style parallel bus cycles.
//   usb_clk, reset_i                  : clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/len    : burst command (len 0 means 1 byte)
//   wdata/wdata_valid/wdata_ready     : write byte stream
//   rdata/rdata_valid                 : read byte stream, no backpressure
//   done                              : pulse after the last byte of a burst
//   usb_addr/data_o/data_oe/data_i    : bus address and split data lines
//   usb_rdn/usb_wrn/usb_cen           : active-low strobes
module cw305_usb_bus_master import cw305_bus_pkg::*; #(
    parameter int pADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int pBYTECNT_SIZE = DEF_BYTECNT_SIZE,
    parameter int pSETUP        = DEF_SETUP,
    parameter int pSTROBE       = DEF_STROBE,
    parameter int pHOLD         = DEF_HOLD
) (
    input  logic                     usb_clk,
    input  logic                     reset_i,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [pADDR_WIDTH-1:0]   cmd_addr,
    input  logic [pBYTECNT_SIZE:0]   cmd_len,
    input  logic [7:0]               wdata,
    input  logic                     wdata_valid,
    output logic                     wdata_ready,
    output logic [7:0]               rdata,
    output logic                     rdata_valid,
    output logic                     done,
    output logic [pADDR_WIDTH-1:0]   usb_addr,
    output logic [7:0]               usb_data_o,
    output logic                     usb_data_oe,
    input  logic [7:0]               usb_data_i,
    output logic                     usb_rdn,
    output logic                     usb_wrn,
    output logic                     usb_cen
);

    localparam int pMAX = max3(pSETUP, pSTROBE, pHOLD);
    localparam int TW   = $clog2(pMAX + 1);
    localparam int CW   = pBYTECNT_SIZE + 1;

    bus_state_e    state_q, state_d;
    logic          wr_q, wr_n, on_bus, load, last;
    logic [CW-1:0] remain_q;
    logic [TW-1:0] load_val;

    cw305_bus_phase_timer #(.pMAX(pMAX)) u_timer (
        .usb_clk  (usb_clk),
        .reset_i  (reset_i),
        .load     (load),
        .load_val (load_val),
        .last     (last)
    );

    assign cmd_ready   = state_q == ST_IDLE && !reset_i;
    assign wdata_ready = state_q == ST_WAIT_DATA && wdata_valid && !reset_i;

    // Reads pass through ST_NEXT between bytes so cen always idles one cycle; writes get that gap from ST_WAIT_DATA.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (cmd_valid) state_d = cmd_write ? ST_WAIT_DATA : ST_SETUP;
            ST_WAIT_DATA: if (wdata_valid) state_d = ST_SETUP;
            ST_SETUP:     if (last) state_d = ST_STROBE;
            ST_STROBE:    if (last) state_d = ST_HOLD;
            ST_HOLD:      if (last) state_d = remain_q == CW'(1) ? ST_DONE : wr_q ? ST_WAIT_DATA : ST_NEXT;
            ST_NEXT:      state_d = ST_SETUP;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        wr_n     = state_q == ST_IDLE ? cmd_write : wr_q;
        on_bus   = state_d inside {ST_SETUP, ST_STROBE, ST_HOLD};
        load     = state_d != state_q;
        load_val = state_d == ST_SETUP ? TW'(pSETUP - 1) : state_d == ST_STROBE ? TW'(pSTROBE - 1) : TW'(pHOLD - 1);
    end

    // Bus strobes are registered from the next state so they switch cleanly on the clock edge.
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            remain_q    <= '0;
            usb_addr    <= '0;
            usb_data_o  <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            usb_cen     <= 1'b1;
            usb_rdn     <= 1'b1;
            usb_wrn     <= 1'b1;
            usb_data_oe <= 1'b0;
        end else begin
            state_q     <= state_d;
            usb_cen     <= !on_bus;
            usb_rdn     <= !(state_d == ST_STROBE && !wr_n);
            usb_wrn     <= !(state_d == ST_STROBE && wr_n);
            usb_data_oe <= on_bus && wr_n;
            done        <= state_d == ST_DONE;
            rdata_valid <= state_q == ST_STROBE && last && !wr_q;
            if (state_q == ST_IDLE && cmd_valid) begin
                wr_q     <= cmd_write;
                usb_addr <= cmd_addr;
                remain_q <= cmd_len == '0 ? CW'(1) : cmd_len;
            end
            if (wdata_ready)
                usb_data_o <= wdata;
            if (state_q == ST_STROBE && last && !wr_q)
                rdata <= usb_data_i;
            if (state_q == ST_HOLD && last) begin
                remain_q <= remain_q - CW'(1);
                if (state_d != ST_DONE)
                    usb_addr <= pADDR_WIDTH'(burst_next_addr(64'(usb_addr), pBYTECNT_SIZE));
            end
        end
    end

endmodule
